// File: rtl/ws2812b_pkg.sv
// rtl/ws2812b_pkg.sv - shared timing defaults and state type for the WS2812B ring transmitter
package ws2812b_pkg;

  localparam int NUM_LEDS_DEF = 12;
  localparam int T_BIT_DEF    = 50;
  localparam int T0H_DEF      = 16;
  localparam int T1H_DEF      = 32;
  localparam int T_LATCH_DEF  = 12000;
  localparam int BITS_PER_LED = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    LATCH = 2'd2
  } tx_state_e;

endpackage

// File: rtl/ws2812b_bit_gen.sv
// rtl/ws2812b_bit_gen.sv - one NRZ bit period per accepted bit, registered output
module ws2812b_bit_gen #(
  parameter int T_BIT = 50,
  parameter int T0H   = 16,
  parameter int T1H   = 32
) (
  input  logic clk,
  input  logic res,
  input  logic bit_valid,
  input  logic bit_val,
  output logic dout,
  output logic bit_ready
);

  localparam int CW = (T_BIT > 1) ? $clog2(T_BIT) : 1;

  logic [CW-1:0] cyc;
  logic [CW-1:0] cyc_nxt;
  logic          cur_bit;
  logic          bit_nxt;
  logic          active;
  logic          active_nxt;

  // A new bit can be taken while idle or on the last cycle of the current one.
  assign bit_ready = !active || (cyc == CW'(T_BIT - 1));

  always_comb begin
    cyc_nxt    = cyc + 1'b1;
    bit_nxt    = cur_bit;
    active_nxt = active;
    if (bit_ready) begin
      cyc_nxt    = '0;
      bit_nxt    = bit_val;
      active_nxt = bit_valid;
    end
  end

  // dout is computed from the next-cycle position so the flop output lines up with cyc.
  always_ff @(posedge clk) begin
    if (res) begin
      cyc     <= '0;
      cur_bit <= 1'b0;
      active  <= 1'b0;
      dout    <= 1'b0;
    end else begin
      cyc     <= cyc_nxt;
      cur_bit <= bit_nxt;
      active  <= active_nxt;
      dout    <= active_nxt && (int'(cyc_nxt) < (bit_nxt ? T1H : T0H));
    end
  end

endmodule

// File: rtl/ws2812b_tx.sv
// rtl/ws2812b_tx.sv - frame snapshot, LED/bit sequencing and latch timing for the 12-LED ring
module ws2812b_tx
  import ws2812b_pkg::*;
#(
  parameter int NUM_LEDS = NUM_LEDS_DEF,
  parameter int T_BIT    = T_BIT_DEF,
  parameter int T0H      = T0H_DEF,
  parameter int T1H      = T1H_DEF,
  parameter int T_LATCH  = T_LATCH_DEF
) (
  input  logic                clk,
  input  logic                res,
  input  logic                start,
  input  logic [NUM_LEDS-1:0] led_mask,
  input  logic [7:0]          intensity,
  output logic                dout,
  output logic                busy,
  output logic                done
);

  localparam int LW  = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int LCW = (T_LATCH > 1) ? $clog2(T_LATCH) : 1;

  tx_state_e           state;
  tx_state_e           state_nxt;
  logic [NUM_LEDS-1:0] mask_q;
  logic [7:0]          int_q;
  logic [LW-1:0]       led_idx;
  logic [LW-1:0]       nxt_led;
  logic [4:0]          bit_idx;
  logic [4:0]          nxt_bit;
  logic [LCW-1:0]      latch_cyc;
  logic                last_bit;
  logic                latch_end;
  logic                bit_valid;
  logic                bit_val;
  logic                bit_ready;

  assign busy      = (state != IDLE);
  assign last_bit  = (led_idx == LW'(NUM_LEDS - 1)) && (bit_idx == 5'd0);
  assign latch_end = (latch_cyc == LCW'(T_LATCH - 1));

  always_comb begin
    nxt_led = led_idx;
    nxt_bit = bit_idx - 1'b1;
    if (bit_idx == 5'd0) begin
      nxt_led = led_idx + 1'b1;
      nxt_bit = 5'(BITS_PER_LED - 1);
    end
  end

  // All three colour bytes carry the same intensity, so the bit within a byte is bit_idx[2:0].
  always_comb begin
    state_nxt = state;
    bit_valid = 1'b0;
    bit_val   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SEND;
          bit_valid = 1'b1;
          bit_val   = led_mask[0] & intensity[7];
        end
      end
      SEND: begin
        bit_valid = !last_bit;
        bit_val   = mask_q[nxt_led] & int_q[nxt_bit[2:0]];
        if (bit_ready && last_bit) begin
          state_nxt = LATCH;
        end
      end
      LATCH: begin
        if (latch_end) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state     <= IDLE;
      mask_q    <= '0;
      int_q     <= '0;
      led_idx   <= '0;
      bit_idx   <= '0;
      latch_cyc <= '0;
      done      <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state == LATCH) && latch_end;
      case (state)
        IDLE: begin
          if (start) begin
            mask_q    <= led_mask;
            int_q     <= intensity;
            led_idx   <= '0;
            bit_idx   <= 5'(BITS_PER_LED - 1);
            latch_cyc <= '0;
          end
        end
        SEND: begin
          if (bit_ready) begin
            if (last_bit) begin
              latch_cyc <= '0;
            end else begin
              led_idx <= nxt_led;
              bit_idx <= nxt_bit;
            end
          end
        end
        LATCH: begin
          latch_cyc <= latch_end ? '0 : latch_cyc + 1'b1;
        end
        default: ;
      endcase
    end
  end

  ws2812b_bit_gen #(
    .T_BIT (T_BIT),
    .T0H   (T0H),
    .T1H   (T1H)
  ) u_bit_gen (
    .clk       (clk),
    .res       (res),
    .bit_valid (bit_valid),
    .bit_val   (bit_val),
    .dout      (dout),
    .bit_ready (bit_ready)
  );

endmodule

// File: tb/tb_ws2812b_tx.sv
// tb/tb_ws2812b_tx.sv - directed bench for ws2812b_tx with a shortened latch period
module tb_ws2812b_tx;

  localparam int NL    = 12;
  localparam int TB    = 50;
  localparam int T0    = 16;
  localparam int T1    = 32;
  localparam int TL    = 1000;
  localparam int NBITS = NL * 24;
  localparam int FRAME = NBITS * TB + TL;

  logic        clk = 1'b0;
  logic        res = 1'b1;
  logic        start = 1'b0;
  logic [11:0] led_mask = '0;
  logic [7:0]  intensity = '0;
  logic        dout;
  logic        busy;
  logic        done;

  int checks = 0;
  int failures = 0;

  int   hi[NBITS];
  int   bad_bits;
  int   lat_bad;
  int   busy_cnt;
  int   done_cnt;
  int   done_at;
  logic dout0;

  always #5 clk = ~clk;

  ws2812b_tx #(
    .NUM_LEDS (NL),
    .T_BIT    (TB),
    .T0H      (T0),
    .T1H      (T1),
    .T_LATCH  (TL)
  ) dut (
    .clk       (clk),
    .res       (res),
    .start     (start),
    .led_mask  (led_mask),
    .intensity (intensity),
    .dout      (dout),
    .busy      (busy),
    .done      (done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_width(input logic [11:0] m, input logic [7:0] v, input int k);
    int   led;
    int   j;
    logic b;
    led = k / 24;
    j   = k % 24;
    b   = m[led] & v[7 - (j % 8)];
    return b ? T1 : T0;
  endfunction

  task automatic begin_frame(input logic [11:0] m, input logic [7:0] v);
    led_mask  = m;
    intensity = v;
    start     = 1'b1;
    tick;
    start     = 1'b0;
  endtask

  // Walks cycles 0..FRAME after the accepting edge; leaves the bench in the done cycle.
  task automatic observe(input logic [11:0] m, input logic [7:0] v, input int restart_at);
    int last_bad;
    bad_bits = 0;
    lat_bad  = 0;
    busy_cnt = 0;
    done_cnt = 0;
    done_at  = -1;
    last_bad = -1;
    dout0    = 1'bx;
    for (int k = 0; k < NBITS; k++) hi[k] = 0;
    for (int n = 0; n <= FRAME; n++) begin
      if (n == 0) dout0 = dout;
      if (n < NBITS * TB) begin
        int   k;
        int   c;
        logic e;
        k = n / TB;
        c = n % TB;
        e = (c < exp_width(m, v, k)) ? 1'b1 : 1'b0;
        if (dout === 1'b1) hi[k]++;
        if (dout !== e && last_bad != k) begin
          bad_bits++;
          last_bad = k;
        end
      end else if (dout !== 1'b0) begin
        lat_bad++;
      end
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        done_cnt++;
        done_at = n;
      end
      if (n < FRAME) begin
        if (restart_at >= 0 && (n == 0 || n == restart_at)) begin
          led_mask  = ~m;
          intensity = ~v;
          start     = (n == restart_at);
        end
        tick;
        start = 1'b0;
      end
    end
  endtask

  task automatic check_frame(input string p);
    check({p, "_first_rise"}, 32'(dout0), 32'd1);
    check({p, "_bad_bits"}, bad_bits, 0);
    check({p, "_latch_dout"}, lat_bad, 0);
    check({p, "_busy_cycles"}, busy_cnt, FRAME);
    check({p, "_done_count"}, done_cnt, 1);
    check({p, "_done_cycle"}, done_at, FRAME);
  endtask

  initial begin
    int ones_first;
    int ones_last;
    int idle_act;

    // Reset and idle
    res = 1'b1;
    repeat (3) tick;
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    res = 1'b0;
    idle_act = 0;
    for (int i = 0; i < 1000; i++) begin
      tick;
      if (dout !== 1'b0 || busy !== 1'b0 || done !== 1'b0) idle_act++;
    end
    check("idle_activity", idle_act, 0);

    // LED 0 lit at intensity 1
    begin_frame(12'h001, 8'h01);
    observe(12'h001, 8'h01, -1);
    check_frame("t2");
    check("t2_w_bit7", hi[7], T1);
    check("t2_w_bit15", hi[15], T1);
    check("t2_w_bit23", hi[23], T1);
    check("t2_w_bit0", hi[0], T0);
    check("t2_w_bit24", hi[24], T0);
    check("t2_w_bit287", hi[287], T0);

    // Back-to-back: start driven in the done cycle, last LED full white
    begin_frame(12'h800, 8'hFF);
    observe(12'h800, 8'hFF, -1);
    check_frame("t3");
    ones_first = 0;
    ones_last  = 0;
    for (int k = 0; k < NBITS; k++) begin
      if (hi[k] > 24) begin
        if (k < 264) ones_first++;
        else ones_last++;
      end
    end
    check("t3_ones_first264", ones_first, 0);
    check("t3_ones_last24", ones_last, 24);

    // Inputs change after capture and a second start mid-frame is ignored
    repeat (3) tick;
    begin_frame(12'hFFF, 8'h5A);
    observe(12'hFFF, 8'h5A, 1000);
    check_frame("t4");
    check("t4_w_bit0", hi[0], T0);
    check("t4_w_bit1", hi[1], T1);
    repeat (5) tick;
    check("t4_not_queued_busy", 32'(busy), 32'd0);

    // Reset mid-frame, then a fresh frame
    begin_frame(12'h3C3, 8'h80);
    repeat (4999) tick;
    check("t5_pre_reset_busy", 32'(busy), 32'd1);
    res = 1'b1;
    tick;
    res = 1'b0;
    check("t5_abort_dout", 32'(dout), 32'd0);
    check("t5_abort_busy", 32'(busy), 32'd0);
    check("t5_abort_done", 32'(done), 32'd0);
    repeat (4) tick;
    check("t5_idle_busy", 32'(busy), 32'd0);
    begin_frame(12'h5A5, 8'hC3);
    observe(12'h5A5, 8'hC3, -1);
    check_frame("t5");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
